// File: rtl/alt_vipvfr130_vfr_control_packet_decoder_pkg.sv
// Shared FSM encoding and control-packet constants for the VFR control-packet decoder.
package alt_vipvfr130_vfr_pkg;

  typedef enum logic [1:0] {
    S_WAIT_SOP = 2'd0,
    S_FORWARD  = 2'd1,
    S_CTRL     = 2'd2
  } vfr_state_e;

  localparam logic [1:0] WAIT_SOP = 2'(S_WAIT_SOP);
  localparam logic [1:0] FORWARD  = 2'(S_FORWARD);
  localparam logic [1:0] CTRL     = 2'(S_CTRL);

  localparam logic [3:0] PKT_VIDEO    = 4'h0;
  localparam logic [3:0] PKT_CTRL     = 4'hF;
  localparam logic [3:0] CTRL_NIBBLES = 4'd9;

  // Nibble counter advance that saturates at the full resolution record.
  function automatic logic [3:0] nib_count_add(input logic [3:0] cnt, input logic [3:0] add);
    logic [4:0] sum;
    sum = {1'b0, cnt} + {1'b0, add};
    return (sum >= {1'b0, CTRL_NIBBLES}) ? CTRL_NIBBLES : sum[3:0];
  endfunction

endpackage

// File: rtl/alt_vipvfr130_vfr_control_packet_decoder_if.sv
// Avalon-ST beat bundle (valid/ready/sop/eop/data) shared by sink and source sides.
interface alt_vipvfr130_vfr_control_packet_decoder_if #(parameter int DATA_W = 24);
  logic              valid;
  logic              ready;
  logic              sop;
  logic              eop;
  logic [DATA_W-1:0] data;

  modport master (output valid, sop, eop, data, input ready);
  modport slave  (input valid, sop, eop, data, output ready);
endinterface

// File: rtl/alt_vipvfr130_vfr_control_packet_decoder_st_pipe_stage.sv
// One-beat registered Avalon-ST stage; takes a beat whenever its register is empty or draining.
module alt_vipvfr130_vfr_st_pipe_stage #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_sop  <= in_sop;
        out_eop  <= in_eop;
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/alt_vipvfr130_vfr_control_packet_decoder.sv
// Splits an Avalon-ST video stream: decodes control packets into width/height/interlace and
// forwards video/user packets. ALT_VIPVFR130_CPD_PASS_CTRL_EN also forwards control packets.
//
// state    | meaning
// WAIT_SOP | between packets, non-sop beats are dropped
// FORWARD  | inside a video/user packet, beats go to dout
// CTRL     | inside a control packet, payload nibbles are collected
module alt_vipvfr130_vfr_control_packet_decoder
  import alt_vipvfr130_vfr_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  alt_vipvfr130_vfr_control_packet_decoder_if.slave  din,
  alt_vipvfr130_vfr_control_packet_decoder_if.master dout,
  output logic [15:0] width,
  output logic [15:0] height,
  output logic [3:0]  interlaced,
  output logic        ctrl_valid,
  output logic        ctrl_error
);

  localparam int DATA_W = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
`ifdef ALT_VIPVFR130_CPD_PASS_CTRL_EN
  localparam logic PASS_CTRL = 1'b1;
`else
  localparam logic PASS_CTRL = 1'b0;
`endif

  logic [1:0] state;
  logic [3:0] nib_cnt;
  logic [3:0] nib_cnt_nxt;
  logic [3:0] nib     [CTRL_NIBBLES];
  logic [3:0] nib_nxt [CTRL_NIBBLES];
  logic       xfer;
  logic       is_ctrl_sop;
  logic       fwd_beat;

  assign xfer        = din.valid && din.ready;
  assign is_ctrl_sop = din.sop && (din.data[3:0] == PKT_CTRL);
  assign nib_cnt_nxt = nib_count_add(nib_cnt, 4'(SYMBOLS_PER_BEAT));

  always_comb begin
    fwd_beat = 1'b0;
    if (din.sop)
      fwd_beat = !is_ctrl_sop || PASS_CTRL;
    else if (state == FORWARD)
      fwd_beat = 1'b1;
    else if (state == CTRL)
      fwd_beat = PASS_CTRL;
  end

  // Symbol s of this beat fills nibble slot nib_cnt+s; slots past the ninth fall away.
  always_comb begin
    for (int k = 0; k < int'(CTRL_NIBBLES); k++) begin
      nib_nxt[k] = nib[k];
      for (int s = 0; s < SYMBOLS_PER_BEAT; s++)
        if (int'(nib_cnt) + s == k)
          nib_nxt[k] = din.data[s*BITS_PER_SYMBOL +: 4];
    end
  end

  alt_vipvfr130_vfr_st_pipe_stage #(.DATA_W(DATA_W)) u_stage (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (din.valid && fwd_beat),
    .in_ready  (din.ready),
    .in_sop    (din.sop),
    .in_eop    (din.eop),
    .in_data   (din.data),
    .out_valid (dout.valid),
    .out_ready (dout.ready),
    .out_sop   (dout.sop),
    .out_eop   (dout.eop),
    .out_data  (dout.data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_SOP;
      nib_cnt    <= '0;
      width      <= '0;
      height     <= '0;
      interlaced <= '0;
      ctrl_valid <= 1'b0;
      ctrl_error <= 1'b0;
      for (int k = 0; k < int'(CTRL_NIBBLES); k++)
        nib[k] <= '0;
    end else begin
      ctrl_valid <= 1'b0;
      ctrl_error <= 1'b0;
      if (xfer) begin
        if (din.sop) begin
          // A new sop cuts short any control packet still collecting.
          if (state == CTRL)
            ctrl_error <= 1'b1;
          nib_cnt <= '0;
          if (is_ctrl_sop) begin
            if (din.eop) begin
              ctrl_error <= 1'b1;
              state      <= WAIT_SOP;
            end else begin
              state <= CTRL;
            end
          end else begin
            state <= din.eop ? WAIT_SOP : FORWARD;
          end
        end else if (state == FORWARD) begin
          if (din.eop)
            state <= WAIT_SOP;
        end else if (state == CTRL) begin
          nib     <= nib_nxt;
          nib_cnt <= nib_cnt_nxt;
          if (din.eop) begin
            state <= WAIT_SOP;
            if (nib_cnt_nxt == CTRL_NIBBLES) begin
              width      <= {nib_nxt[0], nib_nxt[1], nib_nxt[2], nib_nxt[3]};
              height     <= {nib_nxt[4], nib_nxt[5], nib_nxt[6], nib_nxt[7]};
              interlaced <= nib_nxt[8];
              ctrl_valid <= 1'b1;
            end else begin
              ctrl_error <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alt_vipvfr130_vfr_control_packet_decoder.sv
// Directed + randomized bench for the VFR control-packet decoder against a packet-level model.
module tb_alt_vipvfr130_vfr_control_packet_decoder;

  localparam int BPS = 8;
  localparam int SPB = 3;
  localparam int DW  = BPS * SPB;
`ifdef ALT_VIPVFR130_CPD_PASS_CTRL_EN
  localparam bit PASS = 1'b1;
`else
  localparam bit PASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alt_vipvfr130_vfr_control_packet_decoder_if #(.DATA_W(DW)) din_if ();
  alt_vipvfr130_vfr_control_packet_decoder_if #(.DATA_W(DW)) dout_if ();

  logic [15:0] width, height;
  logic [3:0]  interlaced;
  logic        ctrl_valid, ctrl_error;

  alt_vipvfr130_vfr_control_packet_decoder #(
    .BITS_PER_SYMBOL (BPS),
    .SYMBOLS_PER_BEAT(SPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din_if),
    .dout      (dout_if),
    .width     (width),
    .height    (height),
    .interlaced(interlaced),
    .ctrl_valid(ctrl_valid),
    .ctrl_error(ctrl_error)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  typedef enum {M_IDLE, M_FWD, M_CTRL} mtype_e;
  mtype_e      m_type = M_IDLE;
  logic [3:0]  nibq[$];
  logic [25:0] exp_q[$];
  logic        exp_cv = 1'b0, exp_ce = 1'b0;
  logic [15:0] exp_w = '0, exp_h = '0;
  logic [3:0]  exp_i = '0;
  int          cv_count = 0, ce_count = 0, out_count = 0;
  logic        fwd_prev = 1'b0, stall_prev = 1'b0;
  logic [25:0] last_push, stall_beat, obs_beat;
  int          rdy_mode = 0;

  task push_exp(input logic [25:0] b);
    exp_q.push_back(b);
    last_push = b;
    fwd_prev  = 1'b1;
  endtask

  task model_beat(input logic [DW-1:0] d, input logic s, input logic e);
    if (s) begin
      if (m_type == M_CTRL) exp_ce = 1'b1;
      if (d[3:0] == 4'hF) begin
        nibq.delete();
        if (PASS) push_exp({s, e, d});
        if (e) exp_ce = 1'b1;
        m_type = e ? M_IDLE : M_CTRL;
      end else begin
        push_exp({s, e, d});
        m_type = e ? M_IDLE : M_FWD;
      end
    end else if (m_type == M_FWD) begin
      push_exp({s, e, d});
      if (e) m_type = M_IDLE;
    end else if (m_type == M_CTRL) begin
      if (PASS) push_exp({s, e, d});
      for (int k = 0; k < SPB; k++) nibq.push_back(d[k*BPS +: 4]);
      if (e) begin
        m_type = M_IDLE;
        if (nibq.size() >= 9) begin
          exp_cv = 1'b1;
          exp_w  = {nibq[0], nibq[1], nibq[2], nibq[3]};
          exp_h  = {nibq[4], nibq[5], nibq[6], nibq[7]};
          exp_i  = nibq[8];
        end else begin
          exp_ce = 1'b1;
        end
      end
    end
  endtask

  // Per-cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      m_type = M_IDLE;
      nibq.delete();
      exp_q.delete();
      exp_cv = 1'b0; exp_ce = 1'b0;
      exp_w = '0; exp_h = '0; exp_i = '0;
      fwd_prev = 1'b0; stall_prev = 1'b0;
    end else begin
      obs_beat = {dout_if.sop, dout_if.eop, dout_if.data};
      check("ctrl_valid", ctrl_valid, exp_cv);
      check("ctrl_error", ctrl_error, exp_ce);
      check("width", width, exp_w);
      check("height", height, exp_h);
      check("interlaced", interlaced, exp_i);
      check("din_ready", din_if.ready, !dout_if.valid || dout_if.ready);
      if (fwd_prev) begin
        check("latency_valid", dout_if.valid, 1'b1);
        check("latency_beat", obs_beat, last_push);
      end
      if (stall_prev) begin
        check("hold_valid", dout_if.valid, 1'b1);
        check("hold_beat", obs_beat, stall_beat);
      end
      if (dout_if.valid && dout_if.ready) begin
        if (exp_q.size() == 0)
          check("dout_unexpected_qsize", exp_q.size(), 1);
        else begin
          check("dout_beat", obs_beat, exp_q.pop_front());
          out_count++;
        end
      end
      stall_prev = dout_if.valid && !dout_if.ready;
      stall_beat = obs_beat;
      if (ctrl_valid) cv_count++;
      if (ctrl_error) ce_count++;
      exp_cv = 1'b0; exp_ce = 1'b0; fwd_prev = 1'b0;
      if (din_if.valid && din_if.ready)
        model_beat(din_if.data, din_if.sop, din_if.eop);
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       dout_if.ready = ~dout_if.ready;
      2:       dout_if.ready = 1'($urandom_range(0, 1));
      default: dout_if.ready = 1'b1;
    endcase
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
    int t;
    din_if.valid = 1'b1; din_if.data = d; din_if.sop = s; din_if.eop = e;
    t = 0;
    forever begin
      @(negedge clk);
      if (din_if.ready) break;
      t++;
      if (t > 200) begin
        check("send_timeout_ready", din_if.ready, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    din_if.valid = 1'b0; din_if.sop = 1'b0; din_if.eop = 1'b0;
  endtask

  task automatic send_video_pkt(input int len, input logic [3:0] t, input bit gaps, input bit with_eop);
    logic [DW-1:0] d;
    for (int b = 0; b < len; b++) begin
      d = DW'($urandom);
      if (b == 0) d[3:0] = t;
      send_beat(d, b == 0, with_eop && (b == len - 1));
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  task automatic send_ctrl_pkt(input logic [3:0] nibs[$], input bit with_eop, input bit gaps);
    logic [DW-1:0] d;
    int n, nb, idx;
    n  = nibs.size();
    nb = (n + SPB - 1) / SPB;
    d  = DW'($urandom);
    d[3:0] = 4'hF;
    send_beat(d, 1'b1, with_eop && (nb == 0));
    for (int b = 0; b < nb; b++) begin
      for (int s = 0; s < SPB; s++) begin
        idx = b * SPB + s;
        d[s*BPS +: BPS] = (idx < n) ? {4'($urandom), nibs[idx]} : 8'($urandom);
      end
      send_beat(d, 1'b0, with_eop && (b == nb - 1));
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  int c0, e0, o0;
  logic [3:0] rnibs[$];

  initial begin
    din_if.valid = 1'b0; din_if.sop = 1'b0; din_if.eop = 1'b0; din_if.data = '0;
    rst = 1'b1;
    idle(3);
    check("rst_width", width, 16'h0);
    check("rst_height", height, 16'h0);
    check("rst_interlaced", interlaced, 4'h0);
    check("rst_ctrl_valid", ctrl_valid, 1'b0);
    check("rst_ctrl_error", ctrl_error, 1'b0);
    check("rst_dout_valid", dout_if.valid, 1'b0);
    check("rst_dout_sopeop", {dout_if.sop, dout_if.eop}, 2'b00);
    check("rst_dout_data", dout_if.data, 24'h0);
    check("rst_din_ready", din_if.ready, 1'b1);
    rst = 1'b0;
    idle(2);

    // 1920x1080 progressive
    c0 = cv_count; o0 = out_count;
    send_beat(24'h00000F, 1, 0);
    send_beat(24'h080700, 0, 0);
    send_beat(24'h040000, 0, 0);
    send_beat(24'h000803, 0, 1);
    idle(3);
    check("hd_width", width, 16'h0780);
    check("hd_height", height, 16'h0438);
    check("hd_interlaced", interlaced, 4'h0);
    check("hd_pulses", cv_count - c0, 1);
    check("hd_dout_beats", out_count - o0, PASS ? 4 : 0);

    // video packet, 5 beats
    o0 = out_count;
    send_video_pkt(5, 4'h0, 0, 1);
    idle(3);
    check("video_beats", out_count - o0, 5);

    // control eop after 2 payload beats
    e0 = ce_count;
    send_beat(24'h00000F, 1, 0);
    send_beat(24'h0D0200, 0, 0);
    send_beat(24'h020000, 0, 1);
    idle(3);
    check("short_ctrl_error", ce_count - e0, 1);
    check("short_keep_width", width, 16'h0780);
    check("short_keep_height", height, 16'h0438);

    // backpressure toggling
    rdy_mode = 1;
    o0 = out_count;
    send_video_pkt(10, 4'h0, 0, 1);
    idle(6);
    rdy_mode = 0;
    idle(3);
    check("toggle_beats", out_count - o0, 10);
    check("toggle_drain", exp_q.size(), 0);

    // truncated control packet then 720x576 interlaced
    e0 = ce_count; c0 = cv_count;
    send_beat(24'h00000F, 1, 0);
    send_beat(24'h123456, 0, 0);
    send_beat(24'h00000F, 1, 0);
    send_beat(24'h0D0200, 0, 0);
    send_beat(24'h020000, 0, 0);
    send_beat(24'h020004, 0, 1);
    idle(3);
    check("trunc_error", ce_count - e0, 1);
    check("sd_valid", cv_count - c0, 1);
    check("sd_width", width, 16'h02D0);
    check("sd_height", height, 16'h0240);
    check("sd_interlaced", interlaced, 4'h2);

    // header-only control packet
    e0 = ce_count;
    send_beat(24'hABCD0F, 1, 1);
    idle(3);
    check("hdr_only_error", ce_count - e0, 1);
    check("hdr_only_width", width, 16'h02D0);

    // saturation: 12 nibbles, symbol high bits set
    c0 = cv_count;
    send_beat(24'h00000F, 1, 0);
    send_beat(24'hF3E2D1, 0, 0);
    send_beat(24'h060504, 0, 0);
    send_beat(24'h090807, 0, 0);
    send_beat(24'h0C0B0A, 0, 1);
    idle(3);
    check("sat_valid", cv_count - c0, 1);
    check("sat_width", width, 16'h1234);
    check("sat_height", height, 16'h5678);
    check("sat_interlaced", interlaced, 4'h9);

    // abandoned video packet, then stray beats in WAIT_SOP
    o0 = out_count;
    send_video_pkt(3, 4'h0, 0, 0);
    send_video_pkt(3, 4'h5, 0, 1);
    send_beat(24'h000000, 0, 0);
    send_beat(24'h00000F, 0, 1);
    idle(3);
    check("abandon_beats", out_count - o0, 6);

    // reset mid control packet
    send_beat(24'h00000F, 1, 0);
    send_beat(24'h080700, 0, 0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    e0 = ce_count; c0 = cv_count; o0 = out_count;
    send_beat(24'h000803, 0, 1);
    send_video_pkt(2, 4'h0, 0, 1);
    idle(3);
    check("rstmid_width", width, 16'h0);
    check("rstmid_no_error", ce_count - e0, 0);
    check("rstmid_no_valid", cv_count - c0, 0);
    check("rstmid_beats", out_count - o0, 2);

    // randomized traffic
    rdy_mode = 2;
    for (int p = 0; p < 60; p++) begin
      case ($urandom_range(0, 3))
        0: send_video_pkt($urandom_range(1, 6), 4'h0, 1, $urandom_range(0, 7) != 0);
        1: send_video_pkt($urandom_range(1, 6), 4'($urandom_range(1, 14)), 1, $urandom_range(0, 7) != 0);
        2: begin
          rnibs.delete();
          repeat ($urandom_range(0, 12)) rnibs.push_back(4'($urandom));
          send_ctrl_pkt(rnibs, $urandom_range(0, 7) != 0, 1);
        end
        default: send_beat(DW'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      endcase
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rdy_mode = 0;
    idle(10);
    check("random_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alt_vipvfr130_vfr_control_packet_decoder.md
ALT_VIPVFR130_VFR_CONTROL_PACKET_DECODER -- requirements
Module: alt_vipvfr130_vfr_control_packet_decoder

Interface
REQ-001 SHALL have parameter BITS_PER_SYMBOL, default 8: bits per colour-plane symbol, minimum 4.
REQ-002 SHALL have parameter SYMBOLS_PER_BEAT, default 3: symbols in parallel per beat, range 1..4; symbol 0 occupies the LSBs.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports din_valid/din_ready/din_sop/din_eop  in/out/in/in  1 each  Avalon-ST sink handshake and framing, ready latency 0.
REQ-006 SHALL have port din_data  input  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  sink data.
REQ-007 SHALL have ports dout_valid/dout_ready/dout_sop/dout_eop  out/in/out/out  1 each  Avalon-ST source handshake and framing, ready latency 0.
REQ-008 SHALL have port dout_data  output  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  source data.
REQ-009 SHALL have ports width, height  output  16 each  last valid decoded resolution.
REQ-010 SHALL have port interlaced  output  4  last valid decoded interlace nibble.
REQ-011 SHALL have ports ctrl_valid, ctrl_error  output  1 each  single-cycle pulses.

Function
REQ-012 A beat transfers when valid and ready are both high; no other beat has any effect.
REQ-013 Packet type SHALL be the low nibble of symbol 0 of the sop beat: 0x0 video, 0xF control, all others user.
REQ-014 FSM states SHALL be WAIT_SOP, FORWARD, CTRL; a sop beat from any state starts a new packet.
REQ-015 WAIT_SOP: non-sop beats are accepted and discarded.
REQ-016 Video/user sop beat: enter FORWARD; the sop beat and all beats to eop are forwarded unchanged; eop returns to WAIT_SOP.
REQ-017 Control sop beat: enter CTRL, clear nibble counter; the header beat is not forwarded.
REQ-018 CTRL: nibble k (k = 0..8) is the low nibble of symbol (k mod SYMBOLS_PER_BEAT) of payload beat 1 + k/SYMBOLS_PER_BEAT; order width[15:12..3:0], height[15:12..3:0], interlaced[3:0]; symbol bits above bit 3 are ignored.
REQ-019 Nibbles beyond the ninth SHALL be ignored; the nibble counter saturates at 9.
REQ-020 Control eop with 9 nibbles collected: width/height/interlaced update together and ctrl_valid pulses on the cycle after the eop transfer.
REQ-021 Control eop with fewer than 9 nibbles (including sop+eop on the header beat): outputs unchanged; ctrl_error pulses on the next cycle.
REQ-022 sop arriving while in CTRL: treated as truncation, so ctrl_error pulses and outputs are unchanged, then the new packet is decoded normally.
REQ-023 sop arriving while in FORWARD: the previous packet is abandoned without an eop being synthesised.
REQ-024 Output SHALL be one registered pipeline stage: din_ready = !dout_valid || dout_ready; latency exactly 1 cycle; no bubbles under continuous valid/ready.
REQ-025 Non-forwarded beats SHALL obey the same din_ready rule and SHALL NOT load the output register.
REQ-026 dout_data/sop/eop SHALL hold stable while dout_valid is high and dout_ready is low.

Reset
REQ-027 rst: FSM to WAIT_SOP, nibble counter 0, dout_valid 0, dout_sop/eop 0, dout_data 0, width 0, height 0, interlaced 0, ctrl_valid 0, ctrl_error 0.
REQ-028 rst mid-packet SHALL discard the partial packet; the next packet must start with sop.

Configuration
REQ-029 With ALT_VIPVFR130_CPD_PASS_CTRL_EN defined, control packets SHALL also be forwarded beat-for-beat to dout, with decoding unchanged.
REQ-030 Without ALT_VIPVFR130_CPD_PASS_CTRL_EN, control packets SHALL be consumed and never appear on dout.

Structure
REQ-031 Package alt_vipvfr130_vfr_pkg SHALL hold the FSM state enum, packet-type constants (0x0, 0xF), and the nibble count constant 9.
REQ-032 A sub-module alt_vipvfr130_vfr_st_pipe_stage (one-beat registered Avalon-ST stage) SHALL implement REQ-024..026.

Verification
REQ-033 1920x1080 progressive, SPB=3: beats 0x00000F(sop), 0x080700, 0x040000, 0x000803(eop) -> width 0x0780, height 0x0438, interlaced 0, one ctrl_valid pulse, no dout beats (macro off).
REQ-034 Video packet, 0x000000(sop) plus 4 beats with eop on the last, dout_ready held 1 -> 5 identical beats on dout, each 1 cycle later, sop/eop preserved.
REQ-035 Control packet with eop on the second payload beat -> ctrl_error pulse; width/height keep prior values 0x0780/0x0438.
REQ-036 Video stream with dout_ready toggled 1010... -> din_ready follows REQ-024; no beat lost or duplicated.
REQ-037 New sop mid-control packet, then a full 720x576 control packet (interlaced nibble 0x2) -> ctrl_error pulse, then ctrl_valid with width 0x02D0, height 0x0240, interlaced 0x2.
REQ-038 Macro defined, REQ-033 stimulus -> same decode and the 4 beats also appear on dout.
